pc_seq_ctrl: RTL and testbench
==============================

Name: pc_seq_ctrl

Overview:
Multicycle control FSM for the OTTER core. It decides when the PC register loads and which source the PC input mux selects. Sources are PC+4, JALR, BRANCH, JAL, MTVEC and MEPC. It also issues the register-file, memory and CSR write/read strobes for each instruction phase, and sequences interrupt entry and MRET return.

Parameters:
HAS_INTR, 1, when 1 interrupts and MRET are supported; when 0, the INTR state is unreachable, INTR is ignored, and MRET is treated as a NOP (PC_SEL=000).

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  synchronous, active-high reset
OPCODE  input  7  instruction bits [6:0], valid from EXEC onward
FUNC3  input  3  instruction bits [14:12]
BR_EQ  input  1  rs1 == rs2
BR_LT  input  1  rs1 < rs2, signed
BR_LTU  input  1  rs1 < rs2, unsigned
INTR  input  1  external interrupt request, level
MIE  input  1  CSR mstatus.MIE
PC_WRITE  output  1  PC register load enable
PC_SEL  output  3  PC mux select: 000 PC+4, 001 JALR, 010 BRANCH, 011 JAL, 100 MTVEC, 101 MEPC
REG_WRITE  output  1  register file write enable
MEM_RDEN1  output  1  instruction fetch read enable
MEM_RDEN2  output  1  data read enable
MEM_WE2  output  1  data write enable
CSR_WE  output  1  CSR write enable
INT_TAKEN  output  1  interrupt entry strobe; CSR file saves PC to MEPC and clears MIE
STATE  output  2  current state, for debug

Behaviour:
- States: FETCH=00, EXEC=01, WB=10, INTR=11. Outputs are a Moore/Mealy decode of the current state and the inputs.
- Reset:
  - A rising edge with RST=1 forces the state to FETCH.
  - While RST=1, all outputs are forced to 0, including STATE=00.
  - Reset asserted mid-instruction aborts the instruction; no write strobes assert during the reset cycle.
- FETCH:
  - MEM_RDEN1=1; all other strobes 0.
  - Next state is always EXEC.
  - INTR in this state is not sampled.
- EXEC, by OPCODE:
  - LUI 0110111, AUIPC 0010111, OP_IMM 0010011, OP 0110011: REG_WRITE=1, PC_WRITE=1, PC_SEL=000.
  - JAL 1101111: REG_WRITE=1, PC_WRITE=1, PC_SEL=011.
  - JALR 1100111: REG_WRITE=1, PC_WRITE=1, PC_SEL=001.
  - BRANCH 1100011: PC_WRITE=1. PC_SEL=010 if taken, else 000. Taken by FUNC3:
    - 000 BR_EQ; 001 !BR_EQ
    - 100 BR_LT; 101 !BR_LT
    - 110 BR_LTU; 111 !BR_LTU
    - 010/011 never taken
  - STORE 0100011: MEM_WE2=1, PC_WRITE=1, PC_SEL=000.
  - LOAD 0000011: MEM_RDEN2=1, PC_WRITE=0; next state WB.
  - SYSTEM 1110011:
    - FUNC3=000 (MRET): PC_WRITE=1, PC_SEL=101 (000 if HAS_INTR=0).
    - FUNC3!=000 (CSR ops): REG_WRITE=1, CSR_WE=1, PC_WRITE=1, PC_SEL=000.
  - Any other opcode: NOP. PC_WRITE=1, PC_SEL=000, no other strobes.
- WB:
  - REG_WRITE=1, PC_WRITE=1, PC_SEL=000.
  - MEM_RDEN2 stays 0.
- Interrupt pending: PEND = HAS_INTR & INTR & MIE, evaluated combinationally in EXEC (non-LOAD) and in WB.
  - From EXEC (non-LOAD) or WB: next state is INTR if PEND, else FETCH.
  - LOAD never diverts to INTR from EXEC; it is checked after WB.
- INTR:
  - PC_WRITE=1, PC_SEL=100, INT_TAKEN=1 for exactly one cycle; no other strobes.
  - Next state is FETCH.
- Simultaneous events:
  - MRET in EXEC with PEND=1: PC loads MEPC in EXEC, then MTVEC in INTR. MEPC is re-saved as the return target.
  - A taken branch or jump with PEND=1 writes the jump target in EXEC, then MTVEC.
  - INTR deasserted before the EXEC/WB sample point is not taken. No latching of INTR.
- Exactly one PC_WRITE per instruction, plus one for an interrupt. PC_WRITE is never asserted in FETCH.
- Cycle counts:
  - Non-load instruction: 2 cycles.
  - Load: 3 cycles.
  - Interrupt entry adds 1 cycle.

Test Plan:
- RST=1 for 2 cycles mid-EXEC of a STORE -> MEM_WE2=0 and all outputs 0 while RST=1. After release: STATE=00, MEM_RDEN1=1, next STATE=01.
- Branch sweep: OPCODE=1100011, each FUNC3 × {BR_EQ,BR_LT,BR_LTU} combos in EXEC -> PC_SEL=010 only when the taken rule holds (e.g. FUNC3=101, BR_LT=0 -> 010; FUNC3=011 -> 000). PC_WRITE=1 in all cases.
- LOAD with INTR=1, MIE=1 held -> EXEC: MEM_RDEN2=1, PC_WRITE=0. WB: REG_WRITE=1, PC_WRITE=1, PC_SEL=000. INTR state: PC_SEL=100, INT_TAKEN=1. Then FETCH. Total 4 cycles.
- MRET (OPCODE=1110011, FUNC3=000) with INTR=1, MIE=0 -> EXEC PC_SEL=101, next FETCH, INT_TAKEN never 1. Repeat with HAS_INTR=0 -> PC_SEL=000.
- JAL with INTR pulsed only during FETCH -> EXEC PC_SEL=011, REG_WRITE=1, next FETCH, no INTR state.
- Illegal OPCODE=1111111 -> EXEC PC_WRITE=1, PC_SEL=000; REG_WRITE, MEM_WE2 and CSR_WE all 0.

Source files
------------

// File: rtl/pc_seq_ctrl_if.sv
// Control-to-datapath bundle for the OTTER multicycle sequencer: decoded instruction
// fields and branch flags flow in, and PC/strobe controls flow out.
interface pc_seq_ctrl_if;
  logic [6:0] OPCODE;
  logic [2:0] FUNC3;
  logic       BR_EQ;
  logic       BR_LT;
  logic       BR_LTU;
  logic       INTR;
  logic       MIE;
  logic       PC_WRITE;
  logic [2:0] PC_SEL;
  logic       REG_WRITE;
  logic       MEM_RDEN1;
  logic       MEM_RDEN2;
  logic       MEM_WE2;
  logic       CSR_WE;
  logic       INT_TAKEN;
  logic [1:0] STATE;

  modport master (
    output OPCODE, FUNC3, BR_EQ, BR_LT, BR_LTU, INTR, MIE,
    input  PC_WRITE, PC_SEL, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE, INT_TAKEN, STATE
  );

  modport slave (
    input  OPCODE, FUNC3, BR_EQ, BR_LT, BR_LTU, INTR, MIE,
    output PC_WRITE, PC_SEL, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE, INT_TAKEN, STATE
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// OTTER multicycle control FSM: FETCH -> EXEC [-> WB] [-> INTR], with PC load/select and phase strobes.
// Non-load instructions take 2 cycles, loads take 3, and interrupt entry adds 1; there is no stall input.
module pc_seq_ctrl #(
  parameter bit HAS_INTR = 1'b1
) (
  input  logic         CLK,
  input  logic         RST,
  pc_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_WB    = 2'b10,
    ST_INTR  = 2'b11
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t state;
  logic   pend;
  logic   is_load;
  logic   br_taken;

  // INTR is a level; it is not latched, so a request that drops before the sample point is lost.
  assign pend    = HAS_INTR & bus.INTR & bus.MIE;
  assign is_load = (bus.OPCODE == OP_LOAD);

  always_comb begin
    br_taken = 1'b0;
    case (bus.FUNC3)
      3'b000:  br_taken =  bus.BR_EQ;
      3'b001:  br_taken = ~bus.BR_EQ;
      3'b100:  br_taken =  bus.BR_LT;
      3'b101:  br_taken = ~bus.BR_LT;
      3'b110:  br_taken =  bus.BR_LTU;
      3'b111:  br_taken = ~bus.BR_LTU;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: state <= ST_EXEC;
        ST_EXEC:  state <= is_load ? ST_WB : (pend ? ST_INTR : ST_FETCH);
        ST_WB:    state <= pend ? ST_INTR : ST_FETCH;
        default:  state <= ST_FETCH;
      endcase
    end
  end

  // Strobes decode the current state plus live inputs, so reset gates them in the same cycle.
  always_comb begin
    bus.PC_WRITE  = 1'b0;
    bus.PC_SEL    = 3'b000;
    bus.REG_WRITE = 1'b0;
    bus.MEM_RDEN1 = 1'b0;
    bus.MEM_RDEN2 = 1'b0;
    bus.MEM_WE2   = 1'b0;
    bus.CSR_WE    = 1'b0;
    bus.INT_TAKEN = 1'b0;
    bus.STATE     = 2'b00;
    if (!RST) begin
      bus.STATE = state;
      case (state)
        ST_FETCH: bus.MEM_RDEN1 = 1'b1;
        ST_EXEC: begin
          bus.PC_WRITE = 1'b1;
          case (bus.OPCODE)
            OP_LUI, OP_AUIPC, OP_IMM, OP_REG: bus.REG_WRITE = 1'b1;
            OP_JAL: begin
              bus.REG_WRITE = 1'b1;
              bus.PC_SEL    = 3'b011;
            end
            OP_JALR: begin
              bus.REG_WRITE = 1'b1;
              bus.PC_SEL    = 3'b001;
            end
            OP_BRANCH: bus.PC_SEL = br_taken ? 3'b010 : 3'b000;
            OP_STORE:  bus.MEM_WE2 = 1'b1;
            OP_LOAD: begin
              bus.PC_WRITE  = 1'b0;
              bus.MEM_RDEN2 = 1'b1;
            end
            OP_SYSTEM: begin
              if (bus.FUNC3 == 3'b000) begin
                bus.PC_SEL = HAS_INTR ? 3'b101 : 3'b000;
              end else begin
                bus.REG_WRITE = 1'b1;
                bus.CSR_WE    = 1'b1;
              end
            end
            default: bus.PC_SEL = 3'b000;
          endcase
        end
        ST_WB: begin
          bus.REG_WRITE = 1'b1;
          bus.PC_WRITE  = 1'b1;
        end
        default: begin
          bus.PC_WRITE  = 1'b1;
          bus.PC_SEL    = 3'b100;
          bus.INT_TAKEN = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Randomized bench for pc_seq_ctrl: each instruction is expanded into its expected per-cycle
// output sequence from operand values and interrupt levels, then compared cycle by cycle.
module tb_pc_seq_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst0;
  logic rst1;
  int   checks   = 0;
  int   failures = 0;
  int   cur      = 1;

  pc_seq_ctrl_if ifc0();
  pc_seq_ctrl_if ifc1();

  pc_seq_ctrl #(.HAS_INTR(1'b0)) dut0 (.CLK(CLK), .RST(rst0), .bus(ifc0));
  pc_seq_ctrl #(.HAS_INTR(1'b1)) dut1 (.CLK(CLK), .RST(rst1), .bus(ifc1));

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, OPIMM = 7'b0010011, OPR = 7'b0110011;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BRANCH = 7'b1100011;
  localparam logic [6:0] STORE = 7'b0100011, LOAD = 7'b0000011, SYSTEM = 7'b1110011;

  // Packed view: {PC_WRITE, PC_SEL, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE, INT_TAKEN, STATE}
  function automatic logic [11:0] vec(logic pcw, logic [2:0] sel, logic rw, logic rd1, logic rd2,
                                      logic we2, logic csr, logic it, logic [1:0] st);
    return {pcw, sel, rw, rd1, rd2, we2, csr, it, st};
  endfunction

  function automatic logic [11:0] outs(int sel);
    if (sel == 0)
      return {ifc0.PC_WRITE, ifc0.PC_SEL, ifc0.REG_WRITE, ifc0.MEM_RDEN1, ifc0.MEM_RDEN2,
              ifc0.MEM_WE2, ifc0.CSR_WE, ifc0.INT_TAKEN, ifc0.STATE};
    return {ifc1.PC_WRITE, ifc1.PC_SEL, ifc1.REG_WRITE, ifc1.MEM_RDEN1, ifc1.MEM_RDEN2,
            ifc1.MEM_WE2, ifc1.CSR_WE, ifc1.INT_TAKEN, ifc1.STATE};
  endfunction

  task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%b expected=%b", tag, cur, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic intr, input logic mie);
    ifc0.OPCODE = op;  ifc1.OPCODE = op;
    ifc0.FUNC3  = f3;  ifc1.FUNC3  = f3;
    ifc0.BR_EQ  = (a == b);                  ifc1.BR_EQ  = (a == b);
    ifc0.BR_LT  = ($signed(a) < $signed(b)); ifc1.BR_LT  = ($signed(a) < $signed(b));
    ifc0.BR_LTU = (a < b);                   ifc1.BR_LTU = (a < b);
    ifc0.INTR   = intr; ifc1.INTR = intr;
    ifc0.MIE    = mie;  ifc1.MIE  = mie;
  endtask

  task automatic cycle(input string tag, input logic [11:0] exp);
    @(negedge CLK);
    check_val(tag, outs(cur), exp);
    @(posedge CLK);
    #1;
  endtask

  // Instruction semantics: what the EXEC cycle must do, derived from the operands.
  function automatic logic [11:0] exec_exp(logic has, logic [6:0] op, logic [2:0] f3,
                                           logic [31:0] a, logic [31:0] b);
    logic taken;
    taken = 1'b0;
    case (f3)
      3'd0: taken = (a == b);
      3'd1: taken = (a != b);
      3'd4: taken = ($signed(a) <  $signed(b));
      3'd5: taken = ($signed(a) >= $signed(b));
      3'd6: taken = (a <  b);
      3'd7: taken = (a >= b);
      default: taken = 1'b0;
    endcase
    case (op)
      LUI, AUIPC, OPIMM, OPR: return vec(1, 3'd0, 1, 0, 0, 0, 0, 0, 2'b01);
      JAL:    return vec(1, 3'd3, 1, 0, 0, 0, 0, 0, 2'b01);
      JALR:   return vec(1, 3'd1, 1, 0, 0, 0, 0, 0, 2'b01);
      BRANCH: return vec(1, taken ? 3'd2 : 3'd0, 0, 0, 0, 0, 0, 0, 2'b01);
      STORE:  return vec(1, 3'd0, 0, 0, 0, 1, 0, 0, 2'b01);
      LOAD:   return vec(0, 3'd0, 0, 0, 1, 0, 0, 0, 2'b01);
      SYSTEM: return (f3 == 3'd0) ? vec(1, has ? 3'd5 : 3'd0, 0, 0, 0, 0, 0, 0, 2'b01)
                                  : vec(1, 3'd0, 1, 0, 0, 0, 1, 0, 2'b01);
      default: return vec(1, 3'd0, 0, 0, 0, 0, 0, 0, 2'b01);
    endcase
  endfunction

  // intr[k]/mie[k] are the levels presented during the k-th cycle of this instruction.
  task automatic run_instr(input logic has, input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] intr, input logic [3:0] mie);
    logic pend;
    int   k;
    drive(7'($urandom), f3, a, b, intr[0], mie[0]);
    cycle("fetch", vec(0, 3'd0, 0, 1, 0, 0, 0, 0, 2'b00));
    drive(op, f3, a, b, intr[1], mie[1]);
    cycle("exec", exec_exp(has, op, f3, a, b));
    if (op == LOAD) begin
      drive(op, f3, a, b, intr[2], mie[2]);
      cycle("wb", vec(1, 3'd0, 1, 0, 0, 0, 0, 0, 2'b10));
      pend = has & intr[2] & mie[2];
      k = 3;
    end else begin
      pend = has & intr[1] & mie[1];
      k = 2;
    end
    if (pend) begin
      drive(op, f3, a, b, intr[k], mie[k]);
      cycle("intr", vec(1, 3'd4, 0, 0, 0, 0, 0, 1, 2'b11));
    end
  endtask

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 11))
      0: return LUI;    1: return AUIPC;  2: return OPIMM; 3: return OPR;
      4: return JAL;    5: return JALR;   6: return BRANCH; 7: return STORE;
      8: return LOAD;   9: return SYSTEM; 10: return BRANCH;
      default: return 7'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 3))
      0: return 32'h0000_0005;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] pa [5];
    logic [31:0] pb [5];
    pa = '{32'd7, 32'd3, 32'd9, 32'hFFFF_FFFE, 32'd4};
    pb = '{32'd7, 32'd9, 32'd3, 32'd4, 32'hFFFF_FFFE};
    rst0 = 1'b1;
    rst1 = 1'b1;
    drive(7'd0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    cur = 1; cycle("reset_dut1", 12'd0);
    cur = 0; cycle("reset_dut0", 12'd0);
    cur = 1;
    rst1 = 1'b0;

    // Reset asserted for two cycles in the EXEC cycle of a store.
    drive(STORE, 3'd2, 32'd0, 32'd0, 1'b0, 1'b0);
    cycle("pre_store_fetch", vec(0, 3'd0, 0, 1, 0, 0, 0, 0, 2'b00));
    rst1 = 1'b1;
    cycle("rst_mid_exec", 12'd0);
    cycle("rst_hold", 12'd0);
    rst1 = 1'b0;

    run_instr(1'b1, OPIMM, 3'd0, 32'd1, 32'd2, 4'b0000, 4'b0000);
    for (int f = 0; f < 8; f++)
      for (int p = 0; p < 5; p++)
        run_instr(1'b1, BRANCH, 3'(f), pa[p], pb[p], 4'b0000, 4'b1111);
    run_instr(1'b1, LOAD, 3'd2, 32'd0, 32'd0, 4'b1111, 4'b1111);
    run_instr(1'b1, SYSTEM, 3'd0, 32'd0, 32'd0, 4'b1111, 4'b0000);
    run_instr(1'b1, SYSTEM, 3'd0, 32'd0, 32'd0, 4'b1111, 4'b1111);
    run_instr(1'b1, JAL, 3'd0, 32'd0, 32'd0, 4'b0001, 4'b1111);
    run_instr(1'b1, 7'b1111111, 3'd0, 32'd0, 32'd0, 4'b0000, 4'b0000);
    run_instr(1'b1, BRANCH, 3'd0, 32'd5, 32'd5, 4'b1111, 4'b1111);
    run_instr(1'b1, SYSTEM, 3'd1, 32'd0, 32'd0, 4'b0000, 4'b0000);
    for (int i = 0; i < 300; i++)
      run_instr(1'b1, rand_op(), 3'($urandom), rand_opnd(), rand_opnd(), 4'($urandom), 4'($urandom));

    // Same traffic against the build without interrupt support.
    rst1 = 1'b1;
    rst0 = 1'b0;
    cur  = 0;
    run_instr(1'b0, SYSTEM, 3'd0, 32'd0, 32'd0, 4'b1111, 4'b0000);
    run_instr(1'b0, SYSTEM, 3'd0, 32'd0, 32'd0, 4'b1111, 4'b1111);
    run_instr(1'b0, LOAD, 3'd0, 32'd0, 32'd0, 4'b1111, 4'b1111);
    for (int i = 0; i < 100; i++)
      run_instr(1'b0, rand_op(), 3'($urandom), rand_opnd(), rand_opnd(), 4'($urandom), 4'($urandom));
    drive(7'd0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    cycle("final_fetch", vec(0, 3'd0, 0, 1, 0, 0, 0, 0, 2'b00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
